// File: rtl/private_exponent_gen_if.sv
// Handshake and data bundle between the totient stage, the private-exponent
// generator and the decryption stage.
interface private_exponent_gen_if #(
    parameter int SIZE = 12
);
    localparam int W = 2 * SIZE;

    logic         start;
    logic [W-1:0] totient;
    logic [W-1:0] pub_exp;
    logic [W-1:0] priv_exp;
    logic         key_valid;
    logic         done;
    logic         busy;

    modport master (
        output start, totient, pub_exp,
        input  priv_exp, key_valid, done, busy
    );

    modport slave (
        input  start, totient, pub_exp,
        output priv_exp, key_valid, done, busy
    );
endinterface

// File: rtl/private_exponent_gen.sv
// Private exponent d = e^-1 mod phi via iterative extended Euclid, sharing a
// single restoring divider that yields one quotient bit per cycle.
module private_exponent_gen #(
    parameter int SIZE = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    private_exponent_gen_if.slave  bus
);
    localparam int W  = 2 * SIZE;
    localparam int CW = $clog2(W);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_INIT   = 3'd1;
    localparam logic [2:0] S_DIV    = 3'd2;
    localparam logic [2:0] S_UPDATE = 3'd3;
    localparam logic [2:0] S_FIX    = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]          state_q, state_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                key_valid_q, key_valid_d;
    logic                degen_q, degen_d;
    logic [W-1:0]        priv_q, priv_d;
    logic [W-1:0]        phi_q, phi_d;
    logic [W-1:0]        r0_q, r0_d;
    logic [W-1:0]        r1_q, r1_d;
    logic [W-1:0]        rem_q, rem_d;
    logic [W-1:0]        qsh_q, qsh_d;
    logic signed [W:0]   t0_q, t0_d;
    logic signed [W:0]   t1_q, t1_d;
    logic [CW-1:0]       cnt_q, cnt_d;

    logic [W:0]          rem_sh;
    logic                rem_ge;

    // t0 - q*t1 taken modulo 2^(W+1): every true Bezout coefficient fits since |t| <= phi.
    function automatic logic signed [W:0] t_next(input logic signed [W:0] a,
                                                 input logic signed [W:0] b,
                                                 input logic [W-1:0]      q);
        logic [W:0] p;
        p = a - {1'b0, q} * b;
        return p;
    endfunction

    function automatic logic [W-1:0] to_residue(input logic signed [W:0] t,
                                                 input logic [W-1:0]      m);
        logic [W:0] s;
        s = t;
        if (t[W]) s = s + {1'b0, m};
        if (s >= {1'b0, m}) s = s - {1'b0, m};
        return s[W-1:0];
    endfunction

    // Restoring step: qsh shifts the dividend out MSB first and the quotient in.
    assign rem_sh = {rem_q, qsh_q[W-1]};
    assign rem_ge = rem_sh >= {1'b0, r1_q};

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = done_q;
        key_valid_d = key_valid_q;
        degen_d     = degen_q;
        priv_d      = priv_q;
        phi_d       = phi_q;
        r0_d        = r0_q;
        r1_d        = r1_q;
        rem_d       = rem_q;
        qsh_d       = qsh_q;
        t0_d        = t0_q;
        t1_d        = t1_q;
        cnt_d       = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    r0_d    = bus.totient;
                    r1_d    = bus.pub_exp;
                    phi_d   = bus.totient;
                    t0_d    = '0;
                    t1_d    = (W+1)'(1);
                    degen_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                if (phi_q < W'(2) || r1_q == '0) begin
                    degen_d = 1'b1;
                    state_d = S_FIX;
                end else begin
                    qsh_d   = r0_q;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                rem_d = rem_ge ? (rem_sh[W-1:0] - r1_q) : rem_sh[W-1:0];
                qsh_d = {qsh_q[W-2:0], rem_ge};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(W-1)) state_d = S_UPDATE;
            end
            S_UPDATE: begin
                r0_d = r1_q;
                r1_d = rem_q;
                t0_d = t1_q;
                t1_d = t_next(t0_q, t1_q, qsh_q);
                if (rem_q == '0) begin
                    state_d = S_FIX;
                end else begin
                    qsh_d   = r1_q;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = S_DIV;
                end
            end
            S_FIX: begin
                if (!degen_q && r0_q == W'(1)) begin
                    priv_d      = to_residue(t0_q, phi_q);
                    key_valid_d = 1'b1;
                end else begin
                    priv_d      = '0;
                    key_valid_d = 1'b0;
                end
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            key_valid_q <= 1'b0;
            degen_q     <= 1'b0;
            priv_q      <= '0;
            phi_q       <= '0;
            r0_q        <= '0;
            r1_q        <= '0;
            rem_q       <= '0;
            qsh_q       <= '0;
            t0_q        <= '0;
            t1_q        <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            key_valid_q <= key_valid_d;
            degen_q     <= degen_d;
            priv_q      <= priv_d;
            phi_q       <= phi_d;
            r0_q        <= r0_d;
            r1_q        <= r1_d;
            rem_q       <= rem_d;
            qsh_q       <= qsh_d;
            t0_q        <= t0_d;
            t1_q        <= t1_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.priv_exp  = priv_q;
    assign bus.key_valid = key_valid_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_private_exponent_gen.sv
// Scoreboard bench for private_exponent_gen: directed key cases plus random
// operands checked against an arithmetic extended-Euclid model.
module tb_private_exponent_gen;
    localparam int SIZE = 12;
    localparam int W    = 2 * SIZE;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    private_exponent_gen_if #(.SIZE(SIZE)) bus ();
    private_exponent_gen #(.SIZE(SIZE)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [W-1:0] d;
        logic         kv;
        int           lat;
        int           start_cyc;
        logic [W-1:0] phi;
        logic [W-1:0] e;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_x;
    int           checks = 0;
    int           errors = 0;
    int           cyc    = 0;
    logic [W-1:0] held_d  = '0;
    logic         held_kv = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Extended Euclid on plain integers; n = -1 marks the degenerate input case.
    function automatic void model(input longint phi, input longint e,
                                  output longint d, output bit kv, output int n);
        longint r0, r1, t0, t1, q, tmp;
        d = 0; kv = 0; n = 0;
        if (phi < 2 || e == 0) begin
            n = -1;
            return;
        end
        r0 = phi; r1 = e; t0 = 0; t1 = 1;
        while (r1 != 0) begin
            q   = r0 / r1;
            tmp = r0 - q * r1; r0 = r1; r1 = tmp;
            tmp = t0 - q * t1; t0 = t1; t1 = tmp;
            n++;
        end
        kv = (r0 == 1);
        if (kv) d = ((t0 % phi) + phi) % phi;
    endfunction

    task automatic issue(input logic [W-1:0] phi, input logic [W-1:0] e);
        exp_t   x;
        longint d;
        bit     kv;
        int     n;
        int     guard = 0;
        @(negedge clk);
        while (bus.busy === 1'b1 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 5000) begin
            checks++; errors++;
            $display("FAIL issue_wait: busy still %0b after %0d cycles", bus.busy, guard);
            return;
        end
        bus.start   = 1'b1;
        bus.totient = phi;
        bus.pub_exp = e;
        @(posedge clk); #1;
        bus.start = 1'b0;
        model(longint'(phi), longint'(e), d, kv, n);
        x.d         = d[W-1:0];
        x.kv        = kv;
        x.lat       = (n < 0) ? 2 : n * (W + 1) + 2;
        x.start_cyc = cyc;
        x.phi       = phi;
        x.e         = e;
        sb.push_back(x);
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            held_d  = '0;
            held_kv = 1'b0;
        end else if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done: got done=1 required no pending request");
            end else begin
                mon_x = sb.pop_front();
                check("priv_exp", 64'(bus.priv_exp), 64'(mon_x.d));
                check("key_valid", 64'(bus.key_valid), 64'(mon_x.kv));
                check("latency", 64'(cyc - mon_x.start_cyc), 64'(mon_x.lat));
                held_d  = mon_x.d;
                held_kv = mon_x.kv;
            end
        end else begin
            check("hold_priv_exp", 64'(bus.priv_exp), 64'(held_d));
            check("hold_key_valid", 64'(bus.key_valid), 64'(held_kv));
            if (sb.size() > 0) check("busy_during_run", 64'(bus.busy), 64'(1));
        end
    end

    initial begin
        int guard;
        logic [W-1:0] rphi, re;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.totient = '0;
        bus.pub_exp = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_priv_exp", 64'(bus.priv_exp), 64'(0));
        check("rst_key_valid", 64'(bus.key_valid), 64'(0));
        check("rst_done", 64'(bus.done), 64'(0));
        check("rst_busy", 64'(bus.busy), 64'(0));

        // Textbook key, with a competing start while busy that must be ignored.
        issue(24'd3120, 24'd17);
        repeat (4) begin
            bus.start = 1'b1; bus.totient = 24'd40; bus.pub_exp = 24'd3;
            @(posedge clk); #1;
        end
        bus.start = 1'b0;

        issue(24'd40, 24'd3);
        issue(24'd40, 24'd43);
        issue(24'd40, 24'd10);
        issue(24'd40, 24'd40);
        issue(24'd1, 24'd3);
        issue(24'd0, 24'($urandom));
        issue(24'd40, 24'd0);

        for (int i = 0; i < 24; i++) begin
            rphi = 24'($urandom_range(2, 32'hFFFFFF));
            case ($urandom_range(0, 3))
                0:       re = 24'($urandom_range(1, 65537) | 1);
                1:       re = 24'($urandom_range(1, 32'hFFFFFF));
                2:       re = 24'($urandom_range(int'(rphi), 32'hFFFFFF));
                default: re = 24'($urandom_range(1, int'(rphi)));
            endcase
            issue(rphi, re);
        end

        guard = 0;
        while (sb.size() > 0 && guard < 5000) begin
            @(posedge clk);
            guard++;
        end
        if (sb.size() > 0) begin
            checks++; errors++;
            $display("FAIL drain: got %0d pending results required 0", sb.size());
            sb.delete();
        end

        // Abort mid-run with reset: busy drops, and no done may follow.
        issue(24'd3120, 24'd17);
        repeat (20) @(posedge clk);
        #1 rst = 1'b1;
        sb.delete();
        @(posedge clk); #1 rst = 1'b0;
        check("abort_busy", 64'(bus.busy), 64'(0));
        check("abort_priv_exp", 64'(bus.priv_exp), 64'(0));
        check("abort_key_valid", 64'(bus.key_valid), 64'(0));
        repeat (150) @(posedge clk);

        issue(24'd3120, 24'd17);
        guard = 0;
        while (sb.size() > 0 && guard < 500) begin
            @(posedge clk);
            guard++;
        end
        if (sb.size() > 0) begin
            checks++; errors++;
            $display("FAIL final_drain: got %0d pending results required 0", sb.size());
        end
        repeat (4) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
